// File: rtl/fp_mul_tl_pkg.sv
// Shared definitions for the dual-lane binary32 multiplier.
// Holds format constants, special-value encodings, lane indices and the
// encoding of the output serializer state. That encoding is also the
// one-hot result tag driven on res_rdy.
package fp_mul_tl_pkg;

    localparam int SIZE   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // The SEND state is split per lane so that the state register itself
    // is the registered one-hot res_rdy tag (never 2'b11).
    typedef enum logic [1:0] {
        SER_IDLE  = 2'b00,
        SER_SEND0 = 2'b01,
        SER_SEND1 = 2'b10
    } ser_state_e;

endpackage

// File: rtl/fp_mul_lane.sv
// One binary32 multiplier lane: operand capture, a three-stage datapath and
// busy/pending flags.
//   clk     : clock
//   rst     : synchronous active-low reset (control flags only)
//   start_i : load op1_i/op2_i when the lane is idle
//   op1_i   : first operand
//   op2_i   : second operand
//   ack_i   : serializer takes the pending result at this edge
//   pend_o  : result in res_o is waiting to be presented
//   res_o   : packed result
module fp_mul_lane
    import fp_mul_tl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [SIZE-1:0] op1_i,
    input  logic [SIZE-1:0] op2_i,
    input  logic            ack_i,
    output logic            pend_o,
    output logic [SIZE-1:0] res_o
);

    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;

    // Nearest-even rounding; bit MANT_W of the result is the carry-out.
    function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] m,
                                                  input logic g, input logic r,
                                                  input logic st);
        logic up;
        up = g & (r | st | m[0]);
        return {1'b0, m} + {{MANT_W{1'b0}}, up};
    endfunction

    // Exponent range saturation: overflow to signed Inf, underflow to signed zero.
    function automatic logic [SIZE-1:0] pack_sat(input logic s,
                                                 input logic signed [9:0] e,
                                                 input logic [FRAC_W-1:0] f);
        if (e >= 10'sd255)
            return {s, POS_INF[SIZE-2:0]};
        else if (e <= 10'sd0)
            return {s, {(SIZE-1){1'b0}}};
        else
            return {s, e[EXP_W-1:0], f};
    endfunction

    logic                     busy_q, pend_q;
    logic                     vld_p0_q, vld_p1_q, vld_p2_q;
    logic                     take;

    logic [SIZE-1:0]          op1_p0_q, op2_p0_q;

    logic                     sign_p1_d, sign_p1_q;
    logic signed [9:0]        exp_p1_d, exp_p1_q;
    logic [PROD_W-1:0]        prod_p1_d, prod_p1_q;
    logic                     spec_p1_d, spec_p1_q;
    logic [SIZE-1:0]          spec_val_p1_d, spec_val_p1_q;

    logic signed [9:0]        exp_p2_d, exp_p2_q;
    logic [FRAC_W-1:0]        frac_p2_d, frac_p2_q;
    logic                     sign_p2_q, spec_p2_q;
    logic [SIZE-1:0]          spec_val_p2_q;

    logic [SIZE-1:0]          res_p3_d, res_p3_q;

    logic [EXP_W-1:0]         ea, eb;
    logic [FRAC_W-1:0]        fa, fb;
    logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MANT_W-1:0]        mant_n;
    logic                     g_n, r_n, st_n;
    logic signed [9:0]        exp_n;
    logic [MANT_W:0]          mant_r;

    assign take = start_i & ~busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p0_q <= take;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            if (take)
                busy_q <= 1'b1;
            else if (ack_i)
                busy_q <= 1'b0;
            if (vld_p2_q)
                pend_q <= 1'b1;
            else if (ack_i)
                pend_q <= 1'b0;
        end
    end

    // ---- p0 -> p1: unpack, classify, multiply ----
    always_comb begin
        ea = op1_p0_q[FRAC_W +: EXP_W];
        eb = op2_p0_q[FRAC_W +: EXP_W];
        fa = op1_p0_q[FRAC_W-1:0];
        fb = op2_p0_q[FRAC_W-1:0];
        // Zero exponent covers denormals too: they are flushed to zero.
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);

        sign_p1_d = op1_p0_q[SIZE-1] ^ op2_p0_q[SIZE-1];
        exp_p1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
        prod_p1_d = {{MANT_W{1'b0}}, 1'b1, fa} * {{MANT_W{1'b0}}, 1'b1, fb};

        spec_p1_d     = 1'b1;
        spec_val_p1_d = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            spec_val_p1_d = QNAN;
        else if (a_inf || b_inf)
            spec_val_p1_d = {sign_p1_d, POS_INF[SIZE-2:0]};
        else if (a_zero || b_zero)
            spec_val_p1_d = {sign_p1_d, {(SIZE-1){1'b0}}};
        else
            spec_p1_d = 1'b0;
    end

    // ---- p1 -> p2: normalize (at most one position) and round ----
    always_comb begin
        if (prod_p1_q[PROD_W-1]) begin
            mant_n = prod_p1_q[PROD_W-1 -: MANT_W];
            g_n    = prod_p1_q[MANT_W-1];
            r_n    = prod_p1_q[MANT_W-2];
            st_n   = |prod_p1_q[MANT_W-3:0];
            exp_n  = exp_p1_q + 10'sd1;
        end else begin
            mant_n = prod_p1_q[PROD_W-2 -: MANT_W];
            g_n    = prod_p1_q[MANT_W-2];
            r_n    = prod_p1_q[MANT_W-3];
            st_n   = |prod_p1_q[MANT_W-4:0];
            exp_n  = exp_p1_q;
        end
        mant_r = round_rne(mant_n, g_n, r_n, st_n);
        if (mant_r[MANT_W]) begin
            frac_p2_d = mant_r[FRAC_W:1];
            exp_p2_d  = exp_n + 10'sd1;
        end else begin
            frac_p2_d = mant_r[FRAC_W-1:0];
            exp_p2_d  = exp_n;
        end
    end

    // ---- p2 -> p3: range check and pack ----
    always_comb begin
        res_p3_d = spec_p2_q ? spec_val_p2_q : pack_sat(sign_p2_q, exp_p2_q, frac_p2_q);
    end

    always_ff @(posedge clk) begin
        if (take) begin
            op1_p0_q <= op1_i;
            op2_p0_q <= op2_i;
        end
        if (vld_p0_q) begin
            sign_p1_q     <= sign_p1_d;
            exp_p1_q      <= exp_p1_d;
            prod_p1_q     <= prod_p1_d;
            spec_p1_q     <= spec_p1_d;
            spec_val_p1_q <= spec_val_p1_d;
        end
        if (vld_p1_q) begin
            sign_p2_q     <= sign_p1_q;
            exp_p2_q      <= exp_p2_d;
            frac_p2_q     <= frac_p2_d;
            spec_p2_q     <= spec_p1_q;
            spec_val_p2_q <= spec_val_p1_q;
        end
        if (vld_p2_q)
            res_p3_q <= res_p3_d;
    end

    assign pend_o = pend_q;
    assign res_o  = res_p3_q;

endmodule

// File: rtl/fp_mul_tl.sv
// Dual-lane binary32 multiplier top: two identical lanes fed from a shared
// operand bus, with results serialized onto one output bus.
//   clk     : clock
//   rst     : synchronous active-low reset
//   op1/op2 : shared operands
//   in_rdy  : per-lane start strobes (bit k loads lane k)
//   res     : result of the lane tagged by res_rdy; holds when idle
//   res_rdy : registered one-hot tag (01 lane 0, 10 lane 1, 00 none)
module fp_mul_tl
    import fp_mul_tl_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] op1,
    input  logic [SIZE-1:0] op2,
    input  logic [1:0]      in_rdy,
    output logic [SIZE-1:0] res,
    output logic [1:0]      res_rdy
);

    logic [1:0]      pend, ack;
    logic [SIZE-1:0] lane_res [2];
    ser_state_e      state_q;
    logic [SIZE-1:0] res_q;

    fp_mul_lane u_lane0 (
        .clk     (clk),
        .rst     (rst),
        .start_i (in_rdy[LANE0]),
        .op1_i   (op1),
        .op2_i   (op2),
        .ack_i   (ack[LANE0]),
        .pend_o  (pend[LANE0]),
        .res_o   (lane_res[LANE0])
    );

    fp_mul_lane u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .start_i (in_rdy[LANE1]),
        .op1_i   (op1),
        .op2_i   (op2),
        .ack_i   (ack[LANE1]),
        .pend_o  (pend[LANE1]),
        .res_o   (lane_res[LANE1])
    );

    // Lane 0 wins when both are pending; lane 1 is taken on the next edge.
    assign ack[LANE0] = pend[LANE0];
    assign ack[LANE1] = pend[LANE1] & ~pend[LANE0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SER_IDLE;
            res_q   <= '0;
        end else if (ack[LANE0]) begin
            state_q <= SER_SEND0;
            res_q   <= lane_res[LANE0];
        end else if (ack[LANE1]) begin
            state_q <= SER_SEND1;
            res_q   <= lane_res[LANE1];
        end else begin
            state_q <= SER_IDLE;
        end
    end

    assign res     = res_q;
    assign res_rdy = state_q;

endmodule

// File: tb/tb_fp_mul_tl.sv
module tb_fp_mul_tl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [1:0]  in_rdy = '0;
    logic [31:0] res;
    logic [1:0]  res_rdy;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_mul_tl #(.SIZE(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .op1     (op1),
        .op2     (op2),
        .in_rdy  (in_rdy),
        .res     (res),
        .res_rdy (res_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Independent reference: exact integer product, remainder-vs-half rounding.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        logic an, bn, ai, bi, az, bz;
        longint unsigned p, keep, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
        if (ai || bi) return {s, 31'h7F800000};
        if (az || bz) return {s, 31'h0};
        p    = longint'({1'b1, fa}) * longint'({1'b1, fb});
        sh   = p[47] ? 24 : 23;
        e    = ea + eb - 127 + (p[47] ? 1 : 0);
        keep = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 31'h7F800000};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[30:23] = 8'($urandom_range(90, 164));
        return v;
    endfunction

    // Drive operands, let the capture edge pass, drop the strobe.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rdy);
        op1    = a;
        op2    = b;
        in_rdy = rdy;
        tick();
        in_rdy = 2'b00;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rdy, input logic [31:0] want);
        issue(a, b, rdy);
        tick(); tick(); tick();
        chk({tag, "_quiet"}, {30'd0, res_rdy}, 32'd0);
        tick();
        chk({tag, "_rdy"}, {30'd0, res_rdy}, (rdy == 2'b10) ? 32'd2 : 32'd1);
        chk({tag, "_res"}, res, want);
        if (rdy == 2'b11) begin
            tick();
            chk({tag, "_rdy1"}, {30'd0, res_rdy}, 32'd2);
            chk({tag, "_res1"}, res, want);
        end
        tick();
        chk({tag, "_idle"}, {30'd0, res_rdy}, 32'd0);
        chk({tag, "_hold"}, res, want);
    endtask

    initial begin
        logic [31:0] a, b, want, r0;

        // Reset state
        tick(); tick();
        chk("reset_res", res, 32'd0);
        chk("reset_rdy", {30'd0, res_rdy}, 32'd0);
        rst = 1'b1;
        tick();

        // Directed products
        run_op("both_1p5x2",  32'h3FC00000, 32'h40000000, 2'b11, 32'h40400000);
        run_op("neg",         32'hC0400000, 32'h40800000, 2'b01, 32'hC1400000);
        run_op("rne_sticky",  32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002);
        run_op("rne_up",      32'h3FC00001, 32'h3FC00001, 2'b10, 32'h40100002);
        run_op("tie_odd",     32'h3F800001, 32'h3FC00000, 2'b01, 32'h3FC00002);
        run_op("tie_even",    32'h3F800002, 32'h3FA00000, 2'b01, 32'h3FA00002);
        run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 2'b01, 32'h7FC00000);
        run_op("nan_in",      32'h7FC00001, 32'h3F800000, 2'b01, 32'h7FC00000);
        run_op("neg_nan",     32'hFFC00000, 32'hBF800000, 2'b10, 32'h7FC00000);
        run_op("neg_inf",     32'hFF800000, 32'h40000000, 2'b01, 32'hFF800000);
        run_op("overflow",    32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F800000);
        run_op("underflow",   32'h00800000, 32'h3F000000, 2'b01, 32'h00000000);
        run_op("neg_zero",    32'h80000000, 32'h3F800000, 2'b11, 32'h80000000);
        run_op("denorm_ftz",  32'h00000001, 32'h7F000000, 2'b01, 32'h00000000);

        // Lane 1 alone, strobe re-pulsed with other operands while busy
        issue(32'h3F800000, 32'h40400000, 2'b10);
        op1 = 32'h40000000;
        in_rdy = 2'b10;
        tick(); tick(); tick();
        chk("busy_quiet", {30'd0, res_rdy}, 32'd0);
        in_rdy = 2'b00;
        tick();
        chk("busy_rdy", {30'd0, res_rdy}, 32'd2);
        chk("busy_res", res, 32'h40400000);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("busy_noextra", {30'd0, res_rdy}, 32'd0);
        end

        // Back-to-back: new operands accepted on the edge after the result cycle
        issue(32'h40000000, 32'h40000000, 2'b01);
        tick(); tick(); tick(); tick();
        chk("b2b_first", res, 32'h40800000);
        op1 = 32'h40400000;
        op2 = 32'h40400000;
        in_rdy = 2'b01;
        tick();
        in_rdy = 2'b00;
        chk("b2b_gap", {30'd0, res_rdy}, 32'd0);
        tick(); tick(); tick(); tick();
        chk("b2b_rdy", {30'd0, res_rdy}, 32'd1);
        chk("b2b_res", res, 32'h41100000);

        // Reset seen at E2 discards both computations
        issue(32'h3FC00000, 32'h40000000, 2'b11);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_mid_rdy", {30'd0, res_rdy}, 32'd0);
            chk("rst_mid_res", res, 32'd0);
        end

        // Random pairs through both lanes
        for (int i = 0; i < 100; i++) begin
            a = rnd_op();
            b = rnd_op();
            want = ref_mul(a, b);
            issue(a, b, 2'b11);
            tick(); tick(); tick(); tick();
            chk("rnd_rdy0", {30'd0, res_rdy}, 32'd1);
            chk("rnd_lane0", res, want);
            r0 = res;
            tick();
            chk("rnd_rdy1", {30'd0, res_rdy}, 32'd2);
            chk("rnd_lane1", res, want);
            chk("rnd_pair", res, r0);
        end
        tick();
        chk("final_idle", {30'd0, res_rdy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
